// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer. It borrows the shared datapath ALU for every
// add and shift, and keeps only the operand, accumulator and result registers.
module alu_mul_sequencer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] op_a,
  input  logic [WORD_SIZE-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_c
);

  // ALU opcode values, matching the datapath ALU's opcode table
  localparam logic [3:0] ALU_ID_A = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SHL  = 4'h8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] EVAL  = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [WORD_SIZE-1:0] acc;
  logic [WORD_SIZE-1:0] mcand;
  logic [WORD_SIZE-1:0] mplier;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // ALU drive depends only on state; IDLE, EVAL and DONE leave it in pass-through
  always_comb begin
    alu_a  = acc;
    alu_b  = mcand;
    alu_op = ALU_ID_A;
    case (state)
      ADD: begin
        alu_a  = acc;
        alu_b  = mcand;
        alu_op = ALU_ADD;
      end
      SHIFT: begin
        alu_a  = mcand;
        alu_b  = mcand;
        alu_op = ALU_SHL;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EVAL;
      EVAL: begin
        if (mplier == '0)    state_next = DONE;
        else if (mplier[0])  state_next = ADD;
        else                 state_next = SHIFT;
      end
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = EVAL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
          end
        end
        EVAL: begin
          if (mplier == '0) result <= acc;
        end
        ADD: acc <= alu_c;
        SHIFT: begin
          mcand  <= alu_c;
          mplier <= mplier >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;

  localparam logic [3:0] ALU_ID_A = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SHL  = 4'h8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WORD_SIZE(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_c  (alu_c)
  );

  // Shared ALU stand-in: pass-through, add, and shift-left-by-one of operand A
  always_comb begin
    alu_c = alu_a;
    case (alu_op)
      ALU_ADD: alu_c = alu_a + alu_b;
      ALU_SHL: alu_c = alu_a << 1;
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start, then follows the run edge by edge until done (bounded), and
  // watches a few edges past completion for stray done pulses.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input int rePulseEdge, output int edges,
                               output int adds, output int dones,
                               output bit busyOk);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    edges  = 0;
    adds   = 0;
    dones  = 0;
    busyOk = 1'b1;
    while (!done && edges < 60) begin
      if (!busy) busyOk = 1'b0;
      if (alu_op == ALU_ADD) adds++;
      if (edges == rePulseEdge) begin
        start = 1'b1;
        op_a  = 16'd9;
        op_b  = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    if (done) dones = 1;
    if (!busy) busyOk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
  endtask

  int  edges;
  int  adds;
  int  dones;
  bit  busyOk;

  initial begin
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_alu_op", alu_op, ALU_ID_A);
    @(negedge clk);
    reset_n = 1'b1;

    // 3 * 5
    applyStimulus(16'd3, 16'd5, -1, edges, adds, dones, busyOk);
    checkOutput("m3x5_edge", edges, 9);
    checkOutput("m3x5_adds", adds, 2);
    checkOutput("m3x5_result", result, 16'h000F);
    checkOutput("m3x5_busy", busyOk, 1);
    checkOutput("m3x5_dones", dones, 1);
    checkOutput("m3x5_idle_busy", busy, 0);

    // multiplier zero finishes straight from EVAL
    applyStimulus(16'h1234, 16'h0000, -1, edges, adds, dones, busyOk);
    checkOutput("zero_edge", edges, 1);
    checkOutput("zero_adds", adds, 0);
    checkOutput("zero_result", result, 16'h0000);

    // worst-case latency and modulo wrap
    applyStimulus(16'hFFFF, 16'hFFFF, -1, edges, adds, dones, busyOk);
    checkOutput("max_edge", edges, 49);
    checkOutput("max_adds", adds, 16);
    checkOutput("max_result", result, 16'h0001);
    checkOutput("max_busy", busyOk, 1);

    // two's-complement operand
    applyStimulus(16'hFFFD, 16'h0007, -1, edges, adds, dones, busyOk);
    checkOutput("neg_edge", edges, 10);
    checkOutput("neg_result", result, 16'hFFEB);

    // start re-pulsed mid-run with new operands must be ignored
    applyStimulus(16'd3, 16'd5, 3, edges, adds, dones, busyOk);
    checkOutput("repulse_edge", edges, 9);
    checkOutput("repulse_result", result, 16'h000F);
    checkOutput("repulse_dones", dones, 1);
    checkOutput("repulse_idle", busy, 0);

    // asynchronous reset at edge 4 of a 3 * 5 run
    @(negedge clk);
    op_a  = 16'd3;
    op_b  = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    checkOutput("pre_abort_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(16'd2, 16'd2, -1, edges, adds, dones, busyOk);
    checkOutput("post_reset_edge", edges, 6);
    checkOutput("post_reset_result", result, 16'h0004);
    checkOutput("post_reset_dones", dones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
